fp16_unpack: RTL and testbench
==============================

FP16_UNPACK -- requirements
Module: fp16_unpack

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: data_in holds an operand to accept.
REQ-004 SHALL have port data_in, input, 16 bits: IEEE-754 binary16 operand {sign, E[4:0], frac[9:0]}.
REQ-005 SHALL have port in_ready, output, 1 bit: high exactly when state is IDLE.
REQ-006 SHALL have port n_valid, output, 1 bit: one-cycle pulse marking unpacked fields valid.
REQ-007 SHALL have output flags is_nan_out, is_pinf_out, is_ninf_out and is_num, each 1 bit.
REQ-008 SHALL have outputs sign_out (1 bit), mant_out (11 bits, bit 10 = hidden bit) and exp_out (7 bits, two's complement, unbiased).

Function
REQ-009 SHALL accept an operand on a rising edge where in_valid and in_ready are both high; in_valid while in_ready is low SHALL be ignored.
REQ-010 SHALL implement states IDLE and NORM: IDLE->NORM on acceptance of a subnormal; NORM->IDLE when the shifted mant[10] becomes 1; every other acceptance stays in IDLE.
REQ-011 SHALL classify E=31, frac!=0 as NaN: is_nan_out=1, is_num=0, sign_out=input sign, exp_out=+16, mant_out={1,frac}.
REQ-012 SHALL classify E=31, frac=0 as infinity: is_pinf_out=1 if sign=0, else is_ninf_out=1; is_num=0, exp_out=+16, mant_out=0.
REQ-013 SHALL classify E=0, frac=0 as zero: is_num=1, sign_out=input sign, exp_out=-15, mant_out=0.
REQ-014 SHALL classify 1<=E<=30 as normal: is_num=1, exp_out=E-15, mant_out={1,frac}.
REQ-015 SHALL classify E=0, frac!=0 as subnormal: load mant={0,frac} and exp=-14, then in NORM shift mant left by 1 and decrement exp by 1 per cycle until mant[10]=1.
REQ-016 SHALL, for a subnormal whose frac MSB set bit is at index p, use exactly 10-p NORM cycles, giving final exp=-14-(10-p) (range -15..-24).
REQ-017 SHALL pulse n_valid for exactly one cycle: on the cycle after acceptance for non-subnormals, and on the cycle after the final NORM shift for subnormals.
REQ-018 SHALL hold every field output stable from its n_valid pulse until the next acceptance.
REQ-019 SHALL drive all flags to 0 and sign_out to the input sign while a subnormal is in NORM.
REQ-020 SHALL allow back-to-back acceptance in consecutive cycles for non-subnormals (one result per cycle), with n_valid and in_ready high in the same cycle.
REQ-021 SHALL assert exactly one of is_nan_out, is_pinf_out, is_ninf_out or is_num with each n_valid pulse.

Reset
REQ-022 SHALL, while rst_n=0, force state IDLE and n_valid=0, all flags=0, sign_out=0, exp_out=0 and mant_out=0; in_ready SHALL be high after rst_n returns high.
REQ-023 SHALL, when rst_n asserts mid-NORM, abort the operation with no n_valid pulse for it, and accept a new operand on the first edge after release.

Verification
REQ-024 SHALL pass: 0x3C00 accepted at edge T -> n_valid at T+1, sign_out=0, exp_out=0, mant_out=0x400, is_num=1.
REQ-025 SHALL pass: 0x0001 -> in_ready low for 10 cycles, n_valid at T+11, exp_out=7'h68 (-24), mant_out=0x400; 0x0200 -> n_valid at T+2, exp_out=-15, mant_out=0x400.
REQ-026 SHALL pass: 0x7C00 -> is_pinf_out=1, exp_out=16, mant_out=0; 0xFC00 -> is_ninf_out=1, sign_out=1; 0x7E00 -> is_nan_out=1, mant_out=0x600, is_num=0.
REQ-027 SHALL pass: 0x8000 -> is_num=1, sign_out=1, exp_out=7'h71 (-15), mant_out=0.
REQ-028 SHALL pass: 0x4400 then 0x4000 on consecutive edges -> two consecutive n_valid pulses: exp_out 2 then 1, mant_out 0x400 both.
REQ-029 SHALL pass: 0x0001 accepted, rst_n low 3 cycles later -> no n_valid, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/fp16_unpack.sv
// Unpacks an IEEE-754 binary16 operand into sign, hidden-bit mantissa and unbiased exponent.
// Subnormals are normalised one bit per cycle before their result is flagged valid.
module fp16_unpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] data_in,
    output logic        in_ready,
    output logic        n_valid,
    output logic        is_nan_out,
    output logic        is_pinf_out,
    output logic        is_ninf_out,
    output logic        is_num,
    output logic        sign_out,
    output logic [10:0] mant_out,
    output logic [6:0]  exp_out
);

    typedef enum logic {IDLE, NORM} state_t;

    state_t      state_q, state_d;
    logic        nvalid_q, nvalid_d;
    logic        nan_q, nan_d, pinf_q, pinf_d, ninf_q, ninf_d, num_q, num_d;
    logic        sign_q, sign_d;
    logic [10:0] mant_q, mant_d;
    logic [6:0]  exp_q, exp_d;

    logic [4:0]  e_field;
    logic [9:0]  f_field;
    logic [10:0] mant_sh;

    assign e_field = data_in[14:10];
    assign f_field = data_in[9:0];
    assign mant_sh = {mant_q[9:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            nvalid_q <= 1'b0;
            nan_q    <= 1'b0;
            pinf_q   <= 1'b0;
            ninf_q   <= 1'b0;
            num_q    <= 1'b0;
            sign_q   <= 1'b0;
            mant_q   <= '0;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            nvalid_q <= nvalid_d;
            nan_q    <= nan_d;
            pinf_q   <= pinf_d;
            ninf_q   <= ninf_d;
            num_q    <= num_d;
            sign_q   <= sign_d;
            mant_q   <= mant_d;
            exp_q    <= exp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nvalid_d = 1'b0;
        nan_d    = nan_q;
        pinf_d   = pinf_q;
        ninf_d   = ninf_q;
        num_d    = num_q;
        sign_d   = sign_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = data_in[15];
                    nan_d  = 1'b0;
                    pinf_d = 1'b0;
                    ninf_d = 1'b0;
                    num_d  = 1'b0;
                    if (e_field == 5'd31) begin
                        nvalid_d = 1'b1;
                        exp_d    = 7'd16;
                        if (f_field != '0) begin
                            nan_d  = 1'b1;
                            mant_d = {1'b1, f_field};
                        end else begin
                            mant_d = '0;
                            pinf_d = ~data_in[15];
                            ninf_d = data_in[15];
                        end
                    end else if (e_field == '0) begin
                        if (f_field == '0) begin
                            nvalid_d = 1'b1;
                            num_d    = 1'b1;
                            exp_d    = 7'h71;
                            mant_d   = '0;
                        end else begin
                            // Flags stay clear until normalisation finishes.
                            state_d = NORM;
                            exp_d   = 7'h72;
                            mant_d  = {1'b0, f_field};
                        end
                    end else begin
                        nvalid_d = 1'b1;
                        num_d    = 1'b1;
                        exp_d    = {2'b00, e_field} - 7'd15;
                        mant_d   = {1'b1, f_field};
                    end
                end
            end
            NORM: begin
                mant_d = mant_sh;
                exp_d  = exp_q - 7'd1;
                if (mant_sh[10]) begin
                    state_d  = IDLE;
                    nvalid_d = 1'b1;
                    num_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign n_valid     = nvalid_q;
    assign is_nan_out  = nan_q;
    assign is_pinf_out = pinf_q;
    assign is_ninf_out = ninf_q;
    assign is_num      = num_q;
    assign sign_out    = sign_q;
    assign mant_out    = mant_q;
    assign exp_out     = exp_q;

endmodule

// File: tb/tb_fp16_unpack.sv
// Bench for fp16_unpack: directed and random binary16 operands checked against an arithmetic model.
module tb_fp16_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        in_ready, n_valid, is_nan_out, is_pinf_out, is_ninf_out, is_num, sign_out;
    logic [10:0] mant_out;
    logic [6:0]  exp_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          nan, pinf, ninf, num, sign;
        logic [10:0] mant;
        logic [6:0]  ex;
        int          k;
    } model_t;

    fp16_unpack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .in_ready(in_ready), .n_valid(n_valid), .is_nan_out(is_nan_out),
        .is_pinf_out(is_pinf_out), .is_ninf_out(is_ninf_out), .is_num(is_num),
        .sign_out(sign_out), .mant_out(mant_out), .exp_out(exp_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic model_t model(input logic [15:0] d);
        model_t r;
        int e, f, m, ev;
        e = int'(d[14:10]);
        f = int'(d[9:0]);
        r.nan = 0; r.pinf = 0; r.ninf = 0; r.num = 0; r.k = 0;
        r.sign = d[15];
        ev = 0; m = 0;
        if (e == 31) begin
            ev = 16;
            if (f != 0) begin r.nan = 1; m = 1024 + f; end
            else if (d[15]) r.ninf = 1;
            else r.pinf = 1;
        end else if (e == 0 && f == 0) begin
            r.num = 1; ev = -15;
        end else if (e == 0) begin
            r.num = 1; m = f;
            while (m < 1024) begin m = m * 2; r.k++; end
            ev = -14 - r.k;
        end else begin
            r.num = 1; ev = e - 15; m = 1024 + f;
        end
        r.mant = m[10:0];
        r.ex   = ev[6:0];
        return r;
    endfunction

    task automatic check_fields(input string tag, input model_t m);
        chk({tag, "_flags"}, {is_nan_out, is_pinf_out, is_ninf_out, is_num},
            {m.nan, m.pinf, m.ninf, m.num});
        chk({tag, "_sign"}, sign_out, m.sign);
        chk({tag, "_mant"}, mant_out, m.mant);
        chk({tag, "_exp"}, exp_out, m.ex);
    endtask

    // Drives one operand; with junk set, in_valid stays high with other data while busy.
    task automatic send(input logic [15:0] d, input bit junk);
        model_t m;
        int n;
        m = model(d);
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1'b1;
        data_in  = d;
        @(posedge clk);
        @(negedge clk);
        if (junk) data_in = ~d;
        else in_valid = 1'b0;
        n = 0;
        while (n_valid !== 1'b1 && n < 20) begin
            chk("ready_busy", in_ready, 0);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, m.k);
        check_fields("res", m);
        chk("ready_at_valid", in_ready, 1);
        @(negedge clk);
        chk("pulse_end", n_valid, 0);
        check_fields("hold", m);
    endtask

    initial begin
        logic [15:0] d;
        model_t m;

        #1;
        chk("rst_nvalid", n_valid, 0);
        chk("rst_fields", {is_nan_out, is_pinf_out, is_ninf_out, is_num, sign_out, mant_out, exp_out}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", in_ready, 1);

        send(16'h3C00, 0);
        send(16'h0001, 1);
        send(16'h0200, 0);
        send(16'h7C00, 0);
        send(16'hFC00, 0);
        send(16'h7E00, 0);
        send(16'h8000, 0);
        send(16'h83FF, 1);

        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'h4400;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_v1", n_valid, 1);
        chk("b2b_r1", in_ready, 1);
        check_fields("b2b1", model(16'h4400));
        data_in = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_v2", n_valid, 1);
        check_fields("b2b2", model(16'h4000));
        @(negedge clk);
        chk("b2b_end", n_valid, 0);

        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: d = {d[15], 5'd0, 10'($urandom_range(1, 1023))};
                1: d[14:10] = 5'd31;
                2: d[14:10] = 5'd0;
                default: ;
            endcase
            send(d, bit'($urandom_range(0, 1)));
        end

        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_nvalid", n_valid, 0);
        chk("abort_fields", {is_nan_out, is_pinf_out, is_ninf_out, is_num, sign_out, mant_out, exp_out}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold", n_valid, 0);
        end
        rst_n    = 1'b1;
        in_valid = 1'b1;
        data_in  = 16'h3C00;
        #1 chk("abort_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        m = model(16'h3C00);
        chk("post_abort_v", n_valid, 1);
        check_fields("post_abort", m);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_stale_pulse", n_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
